// File: rtl/pipe_skid_en.sv
// pipe_skid_en: two-entry valid/ready register slice (skid buffer).
//
// Both in_rdy and out_vld come straight from flops, so neither the payload
// path nor the ready path crosses this stage combinationally. The load
// enables of the output data flop (out_en) and the skid data flop (skid_en)
// are computed here and exported so enable checkers can bind to them.
//
// Handshake semantics (both sides): a beat transfers on a rising clk edge
// when valid and ready are both 1 in the cycle before that edge; valid must
// not depend on ready, and a held payload stays stable until it transfers.
//
// Optional build macro PIPE_SKID_EN_PERF_EN adds perf_stall_cnt, a
// saturating count of cycles with out_vld & !out_rdy (cleared only by rst).
module pipe_skid_en #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_vld,
    input  logic [W-1:0] in_data,
    output logic         in_rdy,
    output logic         out_vld,
    output logic [W-1:0] out_data,
    input  logic         out_rdy,
    output logic         out_en,
    output logic         skid_en
`ifdef PIPE_SKID_EN_PERF_EN
    ,
    output logic [15:0]  perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    // Current occupancy; kept as a named enum so checkers can observe it.
    state_t       state;
    logic [W-1:0] skid_q;
    logic         acc;
    logic         rel;

    // Handshakes use only registered ready/valid, so they are never X after
    // reset even while in_data is X.
    always_comb begin
        acc = in_vld & in_rdy;
        rel = out_vld & out_rdy;
    end

    // Load enables: output flop takes a new head, skid flop takes the beat
    // that arrives while the head is stalled. Flush suppresses both.
    always_comb begin
        out_en  = 1'b0;
        skid_en = 1'b0;
        if (!flush) begin
            unique case (state)
                EMPTY:   out_en = acc;
                ONE: begin
                    out_en  = acc & rel;
                    skid_en = acc & ~rel;
                end
                FULL:    out_en = rel;
                default: begin
                    out_en  = 1'b0;
                    skid_en = 1'b0;
                end
            endcase
        end
    end

    // Occupancy FSM with registered in_rdy/out_vld; rst beats flush.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state   <= EMPTY;
            out_vld <= 1'b0;
            in_rdy  <= 1'b1;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (acc) begin
                        state   <= ONE;
                        out_vld <= 1'b1;
                        in_rdy  <= 1'b1;
                    end
                end
                ONE: begin
                    if (acc && !rel) begin
                        state   <= FULL;
                        out_vld <= 1'b1;
                        in_rdy  <= 1'b0;
                    end else if (!acc && rel) begin
                        state   <= EMPTY;
                        out_vld <= 1'b0;
                        in_rdy  <= 1'b1;
                    end
                end
                FULL: begin
                    if (rel) begin
                        state   <= ONE;
                        out_vld <= 1'b1;
                        in_rdy  <= 1'b1;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    out_vld <= 1'b0;
                    in_rdy  <= 1'b1;
                end
            endcase
        end
    end

    // Output data flop: new beat from upstream, or the skid entry when the
    // slice drains from FULL. No reset; contents matter only while valid.
    always_ff @(posedge clk) begin
        if (out_en) begin
            out_data <= (state == FULL) ? skid_q : in_data;
        end
    end

    // Skid data flop: absorbs the beat accepted while in_rdy was still high.
    always_ff @(posedge clk) begin
        if (skid_en) begin
            skid_q <= in_data;
        end
    end

`ifdef PIPE_SKID_EN_PERF_EN
    // Saturating stall-cycle counter; flush leaves it untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= 16'h0000;
        end else if (out_vld && !out_rdy && (perf_stall_cnt != 16'hFFFF)) begin
            perf_stall_cnt <= perf_stall_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_skid_en.sv
// Testbench for pipe_skid_en: directed steps plus random traffic, every
// cycle compared against a queue-based model of the slice's contents.
module tb_pipe_skid_en;

    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_vld;
    logic [W-1:0] in_data;
    logic         in_rdy;
    logic         out_vld;
    logic [W-1:0] out_data;
    logic         out_rdy;
    logic         out_en;
    logic         skid_en;
`ifdef PIPE_SKID_EN_PERF_EN
    logic [15:0]  perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    pipe_skid_en #(.W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_vld   (in_vld),
        .in_data  (in_data),
        .in_rdy   (in_rdy),
        .out_vld  (out_vld),
        .out_data (out_data),
        .out_rdy  (out_rdy),
        .out_en   (out_en),
        .skid_en  (skid_en)
`ifdef PIPE_SKID_EN_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    // ---------------- scoreboard / model ----------------
    // exp_q holds the payloads the slice currently owns, oldest first.
    logic [W-1:0] exp_q[$];
    int           stall_exp;
    int           n_checks;
    int           n_pass;
    int           n_fail;
    int           n_delivered;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, advance.
    task automatic step(input logic v, input logic [W-1:0] d, input logic r, input logic f);
        int  sz;
        int  nsz;
        bit  acc;
        bit  rel;
        bit  exp_out_en;
        bit  exp_skid_en;
        in_vld  = v;
        in_data = d;
        out_rdy = r;
        flush   = f;
        #1;
        sz  = exp_q.size();
        acc = (v === 1'b1) && (sz < 2);
        rel = (sz > 0) && (r === 1'b1);
        nsz = f ? 0 : sz - (rel ? 1 : 0) + (acc ? 1 : 0);
        // The output flop loads whenever a different beat becomes the head;
        // the skid flop loads when a second entry appears behind the head.
        exp_out_en  = !f && (nsz > 0) && (rel || sz == 0);
        exp_skid_en = !f && (sz == 1) && (nsz == 2);
        chk("out_vld", {63'd0, out_vld}, {63'd0, sz > 0});
        chk("in_rdy", {63'd0, in_rdy}, {63'd0, sz < 2});
        chk("out_en", {63'd0, out_en}, {63'd0, exp_out_en});
        chk("skid_en", {63'd0, skid_en}, {63'd0, exp_skid_en});
        if (sz > 0) chk("out_data", {32'd0, out_data}, {32'd0, exp_q[0]});
`ifdef PIPE_SKID_EN_PERF_EN
        chk("perf_stall_cnt", {48'd0, perf_stall_cnt}, 64'(stall_exp));
`endif
        @(posedge clk);
        if (sz > 0 && r !== 1'b1 && stall_exp < 65535) stall_exp++;
        if (rel) begin
            void'(exp_q.pop_front());
            n_delivered++;
        end
        if (f) exp_q.delete();
        else if (acc) exp_q.push_back(d);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        flush   = 1'b0;
        in_vld  = 1'b0;
        out_rdy = 1'b0;
        in_data = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        stall_exp = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0; n_pass = 0; n_fail = 0; n_delivered = 0; stall_exp = 0;
        rst = 1'b0; flush = 1'b0; in_vld = 1'b0; in_data = '0; out_rdy = 1'b0;
        #2;
        do_reset();

        // Idle after reset, payload driven X: enables must stay 0, not X.
        for (int i = 0; i < 5; i++) step(1'b0, 'x, $urandom_range(0, 1) != 0, 1'b0);

        // Stream 1..8 back to back with out_rdy held high.
        for (int i = 1; i <= 8; i++) step(1'b1, W'(i), 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b1, 1'b0);
        chk("stream_delivered", 64'(n_delivered), 64'd8);

        // 0xA, 0xB against a stalled sink: FULL, in_rdy low, then drain.
        step(1'b1, 32'hA, 1'b0, 1'b0);
        step(1'b1, 32'hB, 1'b0, 1'b0);
        chk("full_in_rdy", {63'd0, in_rdy}, 64'd0);
        chk("full_head", {32'd0, out_data}, 64'hA);
        step(1'b1, 32'h77, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("after_a_head", {32'd0, out_data}, 64'hB);
        chk("after_a_in_rdy", {63'd0, in_rdy}, 64'd1);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Fill with 0xC/0xD, flush while downstream takes 0xC; 0xD is lost.
        step(1'b1, 32'hC, 1'b0, 1'b0);
        step(1'b1, 32'hD, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);
        chk("flush_out_vld", {63'd0, out_vld}, 64'd0);
        chk("flush_in_rdy", {63'd0, in_rdy}, 64'd1);
        step(1'b1, 32'hE, 1'b0, 1'b0);
        chk("post_flush_data", {32'd0, out_data}, 64'hE);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Flush coinciding with an upstream accept drops that beat.
        step(1'b1, 32'h51, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);

        // Reset in the middle of traffic empties the slice.
        step(1'b1, 32'h21, 1'b0, 1'b0);
        step(1'b1, 32'h22, 1'b0, 1'b0);
        do_reset();
        step(1'b0, '0, 1'b1, 1'b0);

        // Random traffic against the model.
        for (int i = 0; i < 10000; i++) begin
            step($urandom_range(0, 1) != 0, W'($urandom()),
                 $urandom_range(0, 1) != 0, $urandom_range(0, 99) == 0);
        end
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);

`ifdef PIPE_SKID_EN_PERF_EN
        // Hold a stalled beat long enough to saturate the stall counter.
        do_reset();
        step(1'b1, 32'h5A, 1'b0, 1'b0);
        for (int i = 0; i < 70000; i++) step(1'b0, '0, 1'b0, 1'b0);
        chk("perf_saturated", {48'd0, perf_stall_cnt}, 64'hFFFF);
        do_reset();
        chk("perf_reset", {48'd0, perf_stall_cnt}, 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_skid_en.md
Name: pipe_skid_en

Overview:
- Two-entry valid/ready register slice (skid buffer) that breaks the timing path on both data and ready.
- It is the producing side for enable-gated flops. It derives the load enables for its own output and skid data registers, and exports those enables so the enable X-checkers can be bound directly to them.
- Sits between pipeline stages wherever a registered `in_rdy` is required.

Parameters:
- W, 32, payload width in bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous discard of all held entries.
- in_vld  input  1  upstream payload valid.
- in_data  input  W  upstream payload.
- in_rdy  output  1  registered ready to upstream.
- out_vld  output  1  downstream payload valid.
- out_data  output  W  downstream payload, driven directly from the output data flop.
- out_rdy  input  1  downstream ready.
- out_en  output  1  load enable of the output data flop.
- skid_en  output  1  load enable of the skid data flop.

Behaviour:
- State encoding: EMPTY (no entries), ONE (output register valid), FULL (output and skid registers valid).
- Reset (rst=1 at an edge): state=EMPTY, out_vld=0, in_rdy=1. Data flops have no reset; their contents are don't-care while not valid.
- Control outputs:
  - in_rdy = (state != FULL), registered.
  - out_vld = (state != EMPTY), registered.
- Transitions, with acc = in_vld & in_rdy and rel = out_vld & out_rdy:
  - EMPTY, acc: -> ONE; out_en=1, out_data <= in_data.
  - ONE, acc & rel: stay ONE; out_en=1 (back-to-back replace).
  - ONE, acc & !rel: -> FULL; skid_en=1, skid <= in_data.
  - ONE, !acc & rel: -> EMPTY.
  - FULL, rel: -> ONE; out_en=1, out_data <= skid. in_vld is ignored because in_rdy=0.
  - All other cases: hold state; enables 0.
- out_en and skid_en are combinational from state, handshakes and flush. They must never be X once rst has been sampled, including while in_data is X.
- Order is strictly FIFO; no payload is duplicated or dropped except by flush.
- Latency and throughput:
  - Latency in_vld->out_vld is 1 cycle.
  - Sustained throughput is 1/cycle when out_rdy=1.
  - in_rdy falls one cycle after the FULL condition arises. The skid entry absorbs the beat accepted in that cycle.
- Flush:
  - flush=1 -> next state EMPTY, out_vld=0, in_rdy=1.
  - out_en and skid_en are forced to 0 in that cycle.
  - A handshake coincident with flush is discarded: rel is still counted as a transfer downstream; acc is dropped.
- rst has priority over flush. Reset mid-transfer discards all entries identically to flush.
- out_data is stable while out_vld & !out_rdy (stall); out_en=0 throughout.

Optional Feature:
- Macro PIPE_SKID_EN_PERF_EN.
- Defined:
  - Adds output port perf_stall_cnt [15:0].
  - Counts cycles with out_vld & !out_rdy; saturates at 16'hFFFF.
  - Reset to 0 by rst; not cleared by flush.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then idle 5 cycles -> out_vld=0, in_rdy=1, out_en=0, skid_en=0 every cycle; enables never X with in_data driven X.
- Stream 0x1..0x8 on consecutive cycles with out_rdy=1 -> out_data 0x1..0x8 on consecutive cycles, first one cycle after first acc; skid_en never asserted.
- Send 0xA, 0xB with out_rdy=0 -> state FULL, in_rdy=0 on third cycle. Raise out_rdy -> 0xA then 0xB delivered; in_rdy returns to 1 one cycle after 0xA is released.
- FULL with 0xC/0xD held, assert flush with out_rdy=1 -> next cycle out_vld=0, in_rdy=1; 0xD never appears; a subsequent 0xE is delivered normally.
- Random in_vld/out_rdy (50%) for 10k cycles against a reference queue -> exact order match, no loss or duplication. With PIPE_SKID_EN_PERF_EN defined, perf_stall_cnt equals the model's stall count.
- With PIPE_SKID_EN_PERF_EN, hold out_vld=1, out_rdy=0 for 70000 cycles -> perf_stall_cnt saturates at 0xFFFF; rst returns it to 0.
